de_selector_1to4: RTL and testbench

- 1-to-4 demultiplexer (de-selector) with registered outputs.
- The data input iC is steered to the one output selected by {iS1,iS0}; the three unselected outputs are held at the idle level, logic 1.
- Leaf block used wherever a single data line must be routed to one of four destinations, such as enables or strobes fanned out to four sub-units.

---
 rtl/de_selector_pkg.sv | 18 +
 rtl/de_selector_lane.sv | 29 ++
 rtl/de_selector_1to4.sv | 47 ++++
 tb/tb_de_selector_1to4.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/de_selector_pkg.sv
// Shared constants and types for the 1-to-4 de-selector.
package de_selector_pkg;

   // Select is {iS1,iS0}, so two bits address four lanes.
   localparam int SEL_W   = 2;
   localparam int N_LANES = 4;

   // Idle level of a single bit. Replicate it to any lane width.
   localparam logic IDLE_BIT = 1'b1;

   typedef logic [SEL_W-1:0] sel_t;

   // Pack the two select pins into one lane index.
   function automatic sel_t packSel(input logic s1, input logic s0);
      return {s1, s0};
   endfunction

endpackage

// File: rtl/de_selector_lane.sv
// One output lane: a register that loads iC when this lane is selected
// and loads the idle level otherwise.
import de_selector_pkg::*;

module de_selector_lane #(
   parameter int                DATA_W   = 1,
   parameter logic [DATA_W-1:0] IDLE_VAL = {DATA_W{IDLE_BIT}},
   parameter sel_t              LANE_IDX = '0
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic [DATA_W-1:0] iC,
   input  logic [SEL_W-1:0]  iSel,
   output logic [DATA_W-1:0] oZ
);

   // The lane register. Reset is asynchronous and forces idle.
   // Any select that does not match this lane index, X included,
   // falls to idle, so only one lane can carry data.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         oZ <= IDLE_VAL;
      else if (iSel == LANE_IDX)
         oZ <= iC;
      else
         oZ <= IDLE_VAL;
   end

endmodule

// File: rtl/de_selector_1to4.sv
// 1-to-4 de-selector with registered outputs. iC is routed to the lane
// picked by {iS1,iS0}. The other lanes sit at IDLE_VAL. Latency is one cycle.
import de_selector_pkg::*;

module de_selector_1to4 #(
   parameter int                DATA_W   = 1,
   parameter logic [DATA_W-1:0] IDLE_VAL = {DATA_W{IDLE_BIT}}
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic [DATA_W-1:0] iC,
   input  logic              iS1,
   input  logic              iS0,
   output logic [DATA_W-1:0] oZ0,
   output logic [DATA_W-1:0] oZ1,
   output logic [DATA_W-1:0] oZ2,
   output logic [DATA_W-1:0] oZ3
);

   sel_t                          sel;
   logic [N_LANES-1:0][DATA_W-1:0] zLanes;

   assign sel = packSel(iS1, iS0);

   // Build one lane register per output. Every lane sees the same
   // sample of iC and sel, so a select change moves the data in a
   // single edge.
   for (genvar k = 0; k < N_LANES; k++) begin : gLane
      de_selector_lane #(
         .DATA_W   (DATA_W),
         .IDLE_VAL (IDLE_VAL),
         .LANE_IDX (sel_t'(k))
      ) uLane (
         .iClk (iClk),
         .iRst (iRst),
         .iC   (iC),
         .iSel (sel),
         .oZ   (zLanes[k])
      );
   end

   assign oZ0 = zLanes[0];
   assign oZ1 = zLanes[1];
   assign oZ2 = zLanes[2];
   assign oZ3 = zLanes[3];

endmodule

// File: tb/tb_de_selector_1to4.sv
// Bench for de_selector_1to4. It drives a narrow (1-bit) and a wide
// (8-bit) instance from the same selects. Expected lane values go into a
// queue when stimulus is driven and are popped one edge later.
module tb_de_selector_1to4;

   typedef struct {
      logic [3:0]      nar;
      logic [3:0][7:0] wid;
   } exp_t;

   logic       iClk = 1'b0;
   logic       iRst;
   logic       iS1, iS0;
   logic [7:0] cWide;
   logic       cNar;
   logic       nZ0, nZ1, nZ2, nZ3;
   logic [7:0] wZ0, wZ1, wZ2, wZ3;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t lastExp;

   always #5 iClk = ~iClk;

   de_selector_1to4 #(.DATA_W(1)) dutN (
      .iClk(iClk), .iRst(iRst), .iC(cNar), .iS1(iS1), .iS0(iS0),
      .oZ0(nZ0), .oZ1(nZ1), .oZ2(nZ2), .oZ3(nZ3)
   );

   de_selector_1to4 #(.DATA_W(8)) dutW (
      .iClk(iClk), .iRst(iRst), .iC(cWide), .iS1(iS1), .iS0(iS0),
      .oZ0(wZ0), .oZ1(wZ1), .oZ2(wZ2), .oZ3(wZ3)
   );

   function automatic exp_t model(input int sel, input logic [7:0] c);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.nar[k] = (sel == k) ? c[0] : 1'b1;
         e.wid[k] = (sel == k) ? c : 8'hFF;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input exp_t e);
      logic [3:0]      on;
      logic [3:0][7:0] ow;
      on = {nZ3, nZ2, nZ1, nZ0};
      ow = {wZ3, wZ2, wZ1, wZ0};
      checks++;
      assert (on === e.nar) else begin
         errors++;
         $error("FAIL %s narrow lanes got=%b want=%b", tag, on, e.nar);
      end
      checks++;
      assert (ow === e.wid) else begin
         errors++;
         $error("FAIL %s wide lanes got=%h want=%h", tag, ow, e.wid);
      end
   endtask

   // Drive inputs after a falling edge and queue the result expected
   // after the next rising edge.
   task automatic drive(input int sel, input logic [7:0] c);
      @(negedge iClk);
      {iS1, iS0} = 2'(sel);
      cWide = c;
      cNar  = c[0];
      sb.push_back(model(sel, c));
   endtask

   // Clock one edge, then pop and compare.
   task automatic settle(input string tag);
      exp_t e;
      @(posedge iClk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL %s scoreboard empty got=0 want=1", tag);
      end else begin
         e = sb.pop_front();
         chk(tag, e);
         lastExp = e;
      end
   endtask

   task automatic step(input string tag, input int sel, input logic [7:0] c);
      drive(sel, c);
      settle(tag);
   endtask

   initial begin
      exp_t allIdle;
      allIdle = model(-1, 8'h00);

      // Reset is asserted before any clock edge, so outputs must
      // already be idle.
      iRst = 1'b1; cWide = 8'h00; cNar = 1'b0; iS1 = 1'b0; iS0 = 1'b0;
      #2;
      chk("reset_async", allIdle);

      // Release reset with the inputs held. Lane 0 takes iC=0 after the
      // first edge.
      @(negedge iClk);
      iRst = 1'b0;
      #1;
      chk("reset_release_hold", allIdle);
      sb.push_back(model(0, 8'h00));
      settle("reset_first_edge");

      // Sweep every lane for two cycles each, toggling iC. The wide
      // instance gets random upper bits.
      for (int s = 0; s < 4; s++)
         for (int t = 0; t < 2; t++)
            step($sformatf("sweep_s%0d_t%0d", s, t), s,
                 {7'($urandom_range(0, 127)), t[0]});

      // iC equal to idle on the selected lane: every output is idle.
      step("idle_data", 3, 8'hFF);

      // Latency: the new iC must not show before the edge.
      step("lat_pre", 2, 8'h01);
      drive(2, 8'h00);
      #1;
      chk("lat_no_comb", lastExp);
      settle("lat_post");

      // Select switch 00 -> 11 with iC=0. The data moves in one edge.
      step("sw_from", 0, 8'h00);
      step("sw_to", 3, 8'h00);

      // Reset mid-stream forces idle without a clock edge.
      step("mid_pre", 1, 8'h00);
      #2;
      iRst = 1'b1;
      #1;
      chk("mid_async", allIdle);
      @(negedge iClk);
      iRst = 1'b0;
      sb.delete();
      #1;
      chk("mid_release_hold", allIdle);
      sb.push_back(model(1, 8'h00));
      settle("mid_recover");

      // Wide pattern on lane 2.
      step("wide_a5", 2, 8'hA5);
      step("wide_5a_l0", 0, 8'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
